// File: rtl/word_byte_pkg.sv
// Shared types, widths and the low/high byte split for the word-to-byte scheduler.
package word_byte_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  // Low byte is bits 7:0 and high byte is bits 15:8. The first beat takes the
  // low byte when low_first=1, and the second beat takes the other byte.
  function automatic logic [BYTE_W-1:0] byte_sel(
    input logic [WORD_W-1:0] word,
    input logic              low_first,
    input logic              second
  );
    return (low_first ^ second) ? word[BYTE_W-1:0] : word[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The last_grant register changes only when a
// grant is actually taken.
module rr_arb2
  import word_byte_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last_grant;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (advance) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/word_byte_sched.sv
// Two-requester scheduler. It accepts 16-bit words by round-robin and sends
// each one on the 8-bit bus as two beats.
module word_byte_sched
  import word_byte_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_src,
  input  logic              byte_ready
);

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_hold;
  logic              r_src;
  logic [1:0]        w_grant;
  logic              w_window;
  logic              w_accept;
  logic              w_accept_src;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (w_accept),
    .grant   (w_grant)
  );

  // A new word can be taken in BYTE1 when its last beat leaves in the same cycle.
  assign w_window     = !rst && ((r_state == IDLE) || ((r_state == BYTE1) && byte_ready));
  assign req0_ready   = w_window & w_grant[0];
  assign req1_ready   = w_window & w_grant[1];
  assign w_accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_accept_src = req1_valid & req1_ready;

  always_comb begin
    w_state_next = r_state;
    byte_valid   = 1'b0;
    byte_last    = 1'b0;
    byte_data    = '0;
    byte_src     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = BYTE0;
      end
      BYTE0: begin
        byte_valid = 1'b1;
        byte_data  = byte_sel(r_hold, LOW_FIRST, 1'b0);
        if (byte_ready) w_state_next = BYTE1;
      end
      BYTE1: begin
        byte_valid = 1'b1;
        byte_last  = 1'b1;
        byte_data  = byte_sel(r_hold, LOW_FIRST, 1'b1);
        if (byte_ready) w_state_next = w_accept ? BYTE0 : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (!rst) begin
      byte_src = r_src;
    end else begin
      // Outputs read as their reset values for the whole reset cycle.
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      byte_data  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_src   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_hold <= w_accept_src ? req1_data : req0_data;
        r_src  <= w_accept_src;
      end
    end
  end

endmodule

// File: tb/tb_word_byte_sched.sv
// Scoreboard bench that drives two instances in lockstep, one low-byte-first
// and one high-byte-first, and checks both against a queue-level reference model.
module tb_word_byte_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid, byte_ready;
  logic [15:0] req0_data, req1_data;
  logic        lf_r0_ready, lf_r1_ready, lf_valid, lf_last, lf_src;
  logic        hf_r0_ready, hf_r1_ready, hf_valid, hf_last, hf_src;
  logic [7:0]  lf_data, hf_data;

  word_byte_sched #(.LOW_FIRST(1'b1)) u_lf (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(lf_r0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(lf_r1_ready),
    .byte_valid(lf_valid), .byte_data(lf_data), .byte_last(lf_last),
    .byte_src(lf_src), .byte_ready(byte_ready)
  );

  word_byte_sched #(.LOW_FIRST(1'b0)) u_hf (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(hf_r0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(hf_r1_ready),
    .byte_valid(hf_valid), .byte_data(hf_data), .byte_last(hf_last),
    .byte_src(hf_src), .byte_ready(byte_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lf;
    logic [7:0] hf;
    logic       last;
    logic       src;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Model state: beats of accepted words that have not yet left, and the previous winner.
  int    m_beats = 0;
  bit    m_lg = 1'b1;
  bit    m_was_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model evaluates the cycle at negedge and then applies what the next posedge will do.
  initial begin : model
    bit         window, win, e0, e1;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_r0_ready", {lf_r0_ready, hf_r0_ready}, 0);
        chk("rst_r1_ready", {lf_r1_ready, hf_r1_ready}, 0);
        chk("rst_valid", {lf_valid, hf_valid}, 0);
        chk("rst_data", {lf_data, hf_data}, 0);
        chk("rst_last_src", {lf_last, hf_last, lf_src, hf_src}, 0);
        m_beats = 0;
        m_lg = 1'b1;
        m_was_rst = 1'b1;
        sb.delete();
      end else begin
        if (m_was_rst) begin
          chk("post_rst_data", {lf_data, hf_data}, 0);
          chk("post_rst_last_src", {lf_last, hf_last, lf_src, hf_src}, 0);
        end
        m_was_rst = 1'b0;
        chk("valid_lf", lf_valid, m_beats != 0);
        chk("valid_hf", hf_valid, m_beats != 0);
        window = (m_beats == 0) || (m_beats == 1 && byte_ready);
        if (req0_valid && req1_valid) win = !m_lg;
        else win = req1_valid;
        e0 = window && req0_valid && !win;
        e1 = window && req1_valid && win;
        chk("r0_ready_lf", lf_r0_ready, e0);
        chk("r1_ready_lf", lf_r1_ready, e1);
        chk("r0_ready_hf", hf_r0_ready, e0);
        chk("r1_ready_hf", hf_r1_ready, e1);
        if (byte_ready && m_beats > 0) m_beats--;
        if (e0 || e1) begin
          w = e1 ? req1_data : req0_data;
          sb.push_back('{lf: w[7:0],  hf: w[15:8], last: 1'b0, src: win});
          sb.push_back('{lf: w[15:8], hf: w[7:0],  last: 1'b1, src: win});
          m_beats += 2;
          m_lg = win;
          $display("accept src=%0d word=%h t=%0t", win, w, $time);
        end
      end
    end
  end

  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && lf_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat at %0t", lf_data, $time);
        end else begin
          b = sb[0];
          chk("data_lf", lf_data, b.lf);
          chk("data_hf", hf_data, b.hf);
          chk("last_lf", lf_last, b.last);
          chk("last_hf", hf_last, b.last);
          chk("src_lf", lf_src, b.src);
          chk("src_hf", hf_src, b.src);
          if (byte_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v0, input logic [15:0] d0, input bit v1,
                     input logic [15:0] d1, input bit br, input bit r);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    byte_ready = br;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    repeat (3) cyc(0, 16'h0, 0, 16'h0, 1, 1);
    // Single word, then idle
    cyc(1, 16'hA55A, 0, 16'h0, 1, 0);
    repeat (4) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    // Back-to-back fairness
    repeat (10) cyc(1, 16'h1111, 1, 16'h2222, 1, 0);
    repeat (3) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    // Backpressure in BYTE0
    cyc(1, 16'hBEEF, 0, 16'h0, 0, 0);
    repeat (3) cyc(1, 16'h7777, 0, 16'h0, 0, 0);
    repeat (3) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    // Word whose high-first order is 12 then 34
    cyc(1, 16'h1234, 0, 16'h0, 1, 0);
    repeat (3) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    // Reset while in BYTE1, then a tie that req0 must win
    cyc(1, 16'hCAFE, 0, 16'h0, 1, 0);
    cyc(0, 16'h0, 0, 16'h0, 1, 0);
    cyc(0, 16'h0, 0, 16'h0, 1, 1);
    cyc(1, 16'h1357, 1, 16'h2468, 1, 0);
    repeat (3) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    // Requester data changes right after acceptance
    cyc(0, 16'h0, 1, 16'h5678, 1, 0);
    cyc(0, 16'h0, 0, 16'h9ABC, 1, 0);
    repeat (3) cyc(0, 16'h0, 0, 16'h9ABC, 1, 0);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 60,
          16'($urandom), $urandom_range(0, 99) < 75, $urandom_range(0, 199) == 0);
    end
    repeat (6) cyc(0, 16'h0, 0, 16'h0, 1, 0);
    chk("drain_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
